// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern detector.
package seq_det_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int unsigned MAX_LEN     = 8;
    localparam logic [7:0]  DEF_PATTERN = 8'h09;
    localparam logic [3:0]  DEF_LEN     = 4'd4;
    localparam logic        DEF_OVERLAP = 1'b1;

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        logic [3:0] res;
        if (len < 4'd2) begin
            res = 4'd2;
        end else if (len > 4'(MAX_LEN)) begin
            res = 4'(MAX_LEN);
        end else begin
            res = len;
        end
        return res;
    endfunction

    // Mask selecting the low len bits; len is already clamped to 2..8.
    function automatic logic [7:0] len_mask(input logic [3:0] len);
        return 8'((9'd1 << len) - 9'd1);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit history, valid-bit count and pattern compare; emits a registered match pulse.
module seq_match_core
    import seq_det_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       shift_i,
    input  logic       bit_i,
    input  logic [7:0] pattern_i,
    input  logic [3:0] len_i,
    input  logic       overlap_i,
    output logic       match_o
);

    logic [7:0] hist_q, hist_d;
    logic [3:0] valid_q, valid_d;
    logic       match_q, match_d;
    logic [7:0] mask;

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        mask    = len_mask(len_i);
        hist_d  = hist_q;
        valid_d = valid_q;
        match_d = 1'b0;
        if (clear_i) begin
            hist_d  = '0;
            valid_d = '0;
        end else if (shift_i) begin
            hist_d  = {hist_q[6:0], bit_i};
            valid_d = (valid_q == 4'(MAX_LEN)) ? valid_q : valid_q + 4'd1;
            match_d = (valid_d >= len_i) && ((hist_d & mask) == (pattern_i & mask));
            // Non-overlapping mode restarts the window right after a hit.
            if (match_d && !overlap_i) begin
                valid_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q  <= '0;
            valid_q <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            valid_q <= valid_d;
            match_q <= match_d;
        end
    end

    assign match_o = match_q;

endmodule

// File: rtl/seq_det_ctrl.sv
// Byte-to-bit serializer FSM with handshake, detector configuration and a
// saturating match counter around seq_match_core.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    input  logic             clr_cnt,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       byte_q, byte_d;
    logic [7:0]       pattern_q;
    logic [3:0]       len_q;
    logic             overlap_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             handshake;
    logic             cfg_accept;

    assign handshake  = in_valid && in_ready;
    assign cfg_accept = cfg_we && (state_q == ST_IDLE) && !handshake;

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        unique case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    state_d = ST_SHIFT;
                    idx_d   = 3'd7;
                    byte_d  = in_data;
                end
            end
            ST_SHIFT: begin
                if (idx_q != 3'd0) begin
                    idx_d = idx_q - 3'd1;
                end else if (handshake) begin
                    idx_d  = 3'd7;
                    byte_d = in_data;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Accepting at index 0 keeps back-to-back bytes bubble-free.
    always_comb begin
        busy     = (state_q == ST_SHIFT);
        in_ready = !busy || (idx_q == 3'd0);
        ser_bit  = busy ? byte_q[idx_q] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= DEF_LEN;
            overlap_q <= DEF_OVERLAP;
        end else if (cfg_accept) begin
            pattern_q <= cfg_pattern;
            len_q     <= clamp_len(cfg_len);
            overlap_q <= cfg_overlap;
        end
    end

    always_comb begin
        count_d = count_q;
        if (cfg_accept || clr_cnt) begin
            count_d = '0;
        end else if (match && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign match_count = count_q;

    seq_match_core u_core (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (cfg_accept),
        .shift_i   (busy),
        .bit_i     (ser_bit),
        .pattern_i (pattern_q),
        .len_i     (len_q),
        .overlap_i (overlap_q),
        .match_o   (match)
    );

endmodule
